// File: rtl/mux_ndff_pkg.sv
// Shared constants and helpers for the mux-recirculation CDC receiver.
// Enable protocol selectors, minimum synchroniser depth, short-pulse counter width,
// and a saturating increment for that counter.
package mux_ndff_pkg;

  localparam int unsigned MODE_LEVEL  = 0;
  localparam int unsigned MODE_TOGGLE = 1;
  localparam int unsigned SYNC_MIN    = 2;
  localparam int unsigned CNT_W       = 8;
  localparam int unsigned MIN_HI_MAX  = 255;

  // Counter holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mux_ndff_rx_if.sv
// Bus bundle between the clka-domain source and the clkb-domain receiver.
//   en        : per-lane enable, asynchronous to clkb
//   data      : per-lane quasi-static source data, lane k at [k*DW +: DW]
//   err_clr   : clkb-domain pulse clearing all err bits
//   data_sync : synchronised data per lane
//   valid     : one-cycle pulse with each new data_sync value
//   err       : sticky short-pulse/overrun flag per lane
// master = source/observer side, slave = receiver side.
interface mux_ndff_rx_if #(
  parameter int unsigned DW  = 8,
  parameter int unsigned NCH = 2
) ();

  logic [NCH-1:0]    en;
  logic [NCH*DW-1:0] data;
  logic              err_clr;
  logic [NCH*DW-1:0] data_sync;
  logic [NCH-1:0]    valid;
  logic [NCH-1:0]    err;

  modport master (
    output en,
    output data,
    output err_clr,
    input  data_sync,
    input  valid,
    input  err
  );

  modport slave (
    input  en,
    input  data,
    input  err_clr,
    output data_sync,
    output valid,
    output err
  );

endinterface

// File: rtl/mux_ndff_lane.sv
// One receiver lane: N-flop enable synchroniser, edge detect, recirculating data
// register, valid pulse and short-pulse error detection.
//   clkb        : destination clock
//   rstn        : synchronous active-low reset
//   en_i        : asynchronous enable from the source domain
//   data_i      : source data, only ever sampled through the load mux
//   err_clr_i   : clears the sticky error flag (a same-cycle set wins)
//   data_sync_o : synchronised data
//   valid_o     : one-cycle pulse per transfer
//   err_o       : sticky short-pulse/overrun flag
module mux_ndff_lane
  import mux_ndff_pkg::*;
#(
  parameter int unsigned DW          = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MODE        = MODE_LEVEL,
  parameter int unsigned MIN_HI      = 2
) (
  input  logic          clkb,
  input  logic          rstn,
  input  logic          en_i,
  input  logic [DW-1:0] data_i,
  input  logic          err_clr_i,
  output logic [DW-1:0] data_sync_o,
  output logic          valid_o,
  output logic          err_o
);

  localparam int unsigned S = SYNC_STAGES;
  localparam logic [CNT_W-1:0] MinHi = MIN_HI[CNT_W-1:0];

  logic [S-1:0]     sync_q, sync_d;
  logic             sdly_q, sdly_d;
  logic [DW-1:0]    data_q, data_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             seen_q, seen_d;

  logic s_last, rise, fall, tog, ld, short_evt;

  always_comb begin
    s_last = sync_q[S-1];
    rise   = s_last & ~sdly_q;
    fall   = ~s_last & sdly_q;
    tog    = s_last ^ sdly_q;

    sync_d = {sync_q[S-2:0], en_i};
    sdly_d = s_last;

    ld      = (MODE == MODE_TOGGLE) ? tog : s_last;
    data_d  = ld ? data_i : data_q;
    // Level mode keeps loading while high but flags only the first load.
    valid_d = (MODE == MODE_TOGGLE) ? tog : rise;

    if (MODE == MODE_TOGGLE) begin
      // Cycles since the last toggle; the very first toggle has no predecessor.
      cnt_d     = tog ? '0 : sat_inc(cnt_q);
      short_evt = tog & seen_q & (cnt_q < MinHi);
      seen_d    = seen_q | tog;
    end else begin
      // Length of the current synced-high run, judged when it ends.
      cnt_d     = s_last ? sat_inc(cnt_q) : '0;
      short_evt = fall & (cnt_q < MinHi);
      seen_d    = 1'b0;
    end

    err_d = short_evt | (err_q & ~err_clr_i);
  end

  always_ff @(posedge clkb) begin
    if (!rstn) begin
      sync_q  <= '0;
      sdly_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      seen_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      sdly_q  <= sdly_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      seen_q  <= seen_d;
    end
  end

  assign data_sync_o = data_q;
  assign valid_o     = valid_q;
  assign err_o       = err_q;

endmodule

// File: rtl/mux_ndff_rx.sv
// Destination-domain receiver for the mux-recirculation CDC scheme: NCH independent
// lanes, each synchronising its enable and loading quasi-static source data.
//   clkb : destination clock, the only clock
//   rstn : synchronous active-low reset
//   bus  : slave side of mux_ndff_rx_if (en, data, err_clr in; data_sync, valid, err out)
// MODE 0 loads while the synced enable is high; MODE 1 loads once per enable toggle.
module mux_ndff_rx
  import mux_ndff_pkg::*;
#(
  parameter int unsigned DW          = 8,
  parameter int unsigned NCH         = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MODE        = MODE_LEVEL,
  parameter int unsigned MIN_HI      = 2
) (
  input logic          clkb,
  input logic          rstn,
  mux_ndff_rx_if.slave bus
);

  if (SYNC_STAGES < SYNC_MIN) begin : g_bad_sync
    $error("mux_ndff_rx: SYNC_STAGES must be at least 2");
  end
  if (MODE != MODE_LEVEL && MODE != MODE_TOGGLE) begin : g_bad_mode
    $error("mux_ndff_rx: MODE must be 0 or 1");
  end
  if (MIN_HI < 1 || MIN_HI > MIN_HI_MAX) begin : g_bad_min_hi
    $error("mux_ndff_rx: MIN_HI must be in 1..255");
  end

  logic [NCH*DW-1:0] data_sync;
  logic [NCH-1:0]    valid;
  logic [NCH-1:0]    err;

  for (genvar k = 0; k < NCH; k++) begin : g_lane
    mux_ndff_lane #(
      .DW         (DW),
      .SYNC_STAGES(SYNC_STAGES),
      .MODE       (MODE),
      .MIN_HI     (MIN_HI)
    ) u_lane (
      .clkb       (clkb),
      .rstn       (rstn),
      .en_i       (bus.en[k]),
      .data_i     (bus.data[k*DW +: DW]),
      .err_clr_i  (bus.err_clr),
      .data_sync_o(data_sync[k*DW +: DW]),
      .valid_o    (valid[k]),
      .err_o      (err[k])
    );
  end

  assign bus.data_sync = data_sync;
  assign bus.valid     = valid;
  assign bus.err       = err;

endmodule

// File: tb/tb_mux_ndff_rx.sv
// Bench for mux_ndff_rx: a level-mode and a toggle-mode instance share one stimulus
// stream. A reference model sees each enable S cycles late and applies the load,
// valid and short-pulse rules using run/gap timestamps.
module tb_mux_ndff_rx;

  localparam int unsigned DW     = 8;
  localparam int unsigned NCH    = 2;
  localparam int unsigned S      = 2;
  localparam int          MIN_HI = 2;

  logic              clkb = 1'b0;
  logic              rstn;
  logic [NCH-1:0]    en;
  logic [NCH*DW-1:0] data;
  logic              err_clr;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clkb = ~clkb;

  mux_ndff_rx_if #(.DW(DW), .NCH(NCH)) bus_lvl ();
  mux_ndff_rx_if #(.DW(DW), .NCH(NCH)) bus_tog ();

  assign bus_lvl.en      = en;
  assign bus_lvl.data    = data;
  assign bus_lvl.err_clr = err_clr;
  assign bus_tog.en      = en;
  assign bus_tog.data    = data;
  assign bus_tog.err_clr = err_clr;

  mux_ndff_rx #(
    .DW(DW), .NCH(NCH), .SYNC_STAGES(S), .MODE(0), .MIN_HI(MIN_HI)
  ) u_dut_lvl (
    .clkb(clkb),
    .rstn(rstn),
    .bus (bus_lvl)
  );

  mux_ndff_rx #(
    .DW(DW), .NCH(NCH), .SYNC_STAGES(S), .MODE(1), .MIN_HI(MIN_HI)
  ) u_dut_tog (
    .clkb(clkb),
    .rstn(rstn),
    .bus (bus_tog)
  );

  // ---------------- reference model (index 0 = level, 1 = toggle) ----------------
  bit            hist   [NCH][S+1];  // hist[k][i]: en as captured i edges ago
  logic [DW-1:0] m_data [2][NCH];
  bit            m_valid[2][NCH];
  bit            m_err  [2][NCH];
  int            rise_t [NCH];
  int            last_t [NCH];
  bit            seen   [NCH];
  int            ecnt = 0;

  always @(posedge clkb) begin
    ecnt++;
    for (int k = 0; k < NCH; k++) begin
      if (!rstn) begin
        for (int i = 0; i <= S; i++) hist[k][i] = 1'b0;
        for (int m = 0; m < 2; m++) begin
          m_data[m][k]  = '0;
          m_valid[m][k] = 1'b0;
          m_err[m][k]   = 1'b0;
        end
        seen[k] = 1'b0;
      end else begin : blk_lane
        bit y, yp, tog, set0, set1;
        y   = hist[k][S-1];  // enable as seen by the logic this cycle
        yp  = hist[k][S];    // and one cycle earlier
        tog = y ^ yp;
        // level mode
        if (y) m_data[0][k] = data[k*DW +: DW];
        m_valid[0][k] = y & ~yp;
        if (y && !yp) rise_t[k] = ecnt;
        set0 = !y && yp && ((ecnt - rise_t[k]) < MIN_HI);
        m_err[0][k] = set0 | (m_err[0][k] & !err_clr);
        // toggle mode
        if (tog) m_data[1][k] = data[k*DW +: DW];
        m_valid[1][k] = tog;
        set1 = tog && seen[k] && ((ecnt - last_t[k] - 1) < MIN_HI);
        if (tog) begin
          seen[k]   = 1'b1;
          last_t[k] = ecnt;
        end
        m_err[1][k] = set1 | (m_err[1][k] & !err_clr);
        for (int i = S; i > 0; i--) hist[k][i] = hist[k][i-1];
        hist[k][0] = en[k];
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [NCH*DW-1:0] exp_data(input int m);
    logic [NCH*DW-1:0] v;
    for (int k = 0; k < NCH; k++) v[k*DW +: DW] = m_data[m][k];
    return v;
  endfunction

  function automatic logic [NCH-1:0] exp_valid(input int m);
    logic [NCH-1:0] v;
    for (int k = 0; k < NCH; k++) v[k] = m_valid[m][k];
    return v;
  endfunction

  function automatic logic [NCH-1:0] exp_err(input int m);
    logic [NCH-1:0] v;
    for (int k = 0; k < NCH; k++) v[k] = m_err[m][k];
    return v;
  endfunction

  task automatic check_all();
    check_eq("lvl_data",  32'(bus_lvl.data_sync), 32'(exp_data(0)));
    check_eq("lvl_valid", 32'(bus_lvl.valid),     32'(exp_valid(0)));
    check_eq("lvl_err",   32'(bus_lvl.err),       32'(exp_err(0)));
    check_eq("tog_data",  32'(bus_tog.data_sync), 32'(exp_data(1)));
    check_eq("tog_valid", 32'(bus_tog.valid),     32'(exp_valid(1)));
    check_eq("tog_err",   32'(bus_tog.err),       32'(exp_err(1)));
  endtask

  // Advance n cycles; outputs are checked on each falling edge, inputs change after.
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clkb);
      check_all();
    end
  endtask

  initial begin
    rstn    = 1'b0;
    en      = 2'b11;
    data    = 16'hFFFF;
    err_clr = 1'b0;

    // Reset held with enables high: everything stays zero.
    tick(2);
    check_eq("rst_data", 32'(bus_lvl.data_sync), 32'h0);
    check_eq("rst_valid", 32'(bus_lvl.valid), 32'h0);
    check_eq("rst_err", 32'(bus_lvl.err), 32'h0);
    rstn = 1'b1;
    tick(3);
    check_eq("rel_lvl_data", 32'(bus_lvl.data_sync), 32'hFFFF);
    check_eq("rel_lvl_valid", 32'(bus_lvl.valid), 32'h3);
    check_eq("rel_tog_data", 32'(bus_tog.data_sync), 32'hFFFF);
    en = 2'b00;
    tick(6);

    // Level mode basic transfer.
    data = 16'h0055;
    en   = 2'b01;
    tick(3);
    check_eq("lvl_basic_data", 32'(bus_lvl.data_sync[7:0]), 32'h55);
    check_eq("lvl_basic_vld1", 32'(bus_lvl.valid[0]), 32'h1);
    tick(1);
    check_eq("lvl_basic_vld2", 32'(bus_lvl.valid[0]), 32'h0);
    tick(2);
    en = 2'b00;
    tick(6);
    check_eq("lvl_basic_err", 32'(bus_lvl.err[0]), 32'h0);

    // Short pulse, then clear.
    data = 16'h00FF;
    en   = 2'b01;
    tick(1);
    en = 2'b00;
    tick(5);
    check_eq("short_data", 32'(bus_lvl.data_sync[7:0]), 32'hFF);
    check_eq("short_err", 32'(bus_lvl.err[0]), 32'h1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check_eq("short_clr", 32'(bus_lvl.err[0]), 32'h0);
    tick(3);

    // Toggle mode: two well-spaced toggles, then two close ones.
    data = 16'h00AC;
    en   = 2'b01;
    tick(3);
    check_eq("tog1_data", 32'(bus_tog.data_sync[7:0]), 32'hAC);
    check_eq("tog1_valid", 32'(bus_tog.valid[0]), 32'h1);
    tick(7);
    data = 16'h003C;
    en   = 2'b00;
    tick(3);
    check_eq("tog2_data", 32'(bus_tog.data_sync[7:0]), 32'h3C);
    check_eq("tog2_valid", 32'(bus_tog.valid[0]), 32'h1);
    check_eq("tog2_err", 32'(bus_tog.err[0]), 32'h0);
    tick(4);
    data = 16'h005A;
    en   = 2'b01;
    tick(1);
    en = 2'b00;
    tick(5);
    check_eq("tog_fast_err", 32'(bus_tog.err[0]), 32'h1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    tick(2);

    // Both lanes in the same cycle.
    data = 16'h3412;
    en   = 2'b11;
    tick(3);
    check_eq("multi_lvl_data", 32'(bus_lvl.data_sync), 32'h3412);
    check_eq("multi_lvl_valid", 32'(bus_lvl.valid), 32'h3);
    check_eq("multi_tog_data", 32'(bus_tog.data_sync), 32'h3412);
    check_eq("multi_tog_valid", 32'(bus_tog.valid), 32'h3);
    tick(3);
    en = 2'b00;
    tick(6);

    // Set beats clear: lane1 error lands in the err_clr cycle, lane0 is cleared.
    en = 2'b01;
    tick(1);
    en = 2'b00;
    tick(6);
    en = 2'b10;
    tick(1);
    en = 2'b00;
    tick(2);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check_eq("prec_lvl_err", 32'(bus_lvl.err), 32'h2);
    check_eq("prec_tog_err", 32'(bus_tog.err), 32'h2);
    tick(4);

    // Random traffic with occasional resets and clears.
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < NCH; k++) begin
        if ($urandom_range(0, 7) == 0) en[k] = ~en[k];
      end
      data    = 16'($urandom);
      err_clr = ($urandom_range(0, 15) == 0);
      rstn    = ($urandom_range(0, 99) != 0);
      tick(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
